// File: rtl/memarb.sv
// memarb: round-robin arbiter sharing the DDR controller command port among PORTS clients.
// It routes acks and data through a queue of burst owners. Define MEMARB_PRIO_EN to give port 0 absolute priority.
//
//   state | meaning
//   IDLE  | pick a requesting port when a queue slot is free, and latch its command
//   REQ   | drive the latched command until the controller accepts it
module memarb #(
    parameter int PORTS  = 4,
    parameter int QDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PORTS-1:0]      memreq,
    input  logic [PORTS-1:0]      memwr,
    input  logic [23*PORTS-1:0]   memaddr,
    input  logic [2*PORTS-1:0]    memlen,
    input  logic [32*PORTS-1:0]   memwdata,
    output logic [PORTS-1:0]      memready,
    output logic [PORTS-1:0]      memack,
    output logic [31:0]           memrdata,
    output logic                  dreq,
    output logic                  dwr,
    output logic [22:0]           daddr,
    output logic [1:0]            dlen,
    output logic [31:0]           dwdata,
    input  logic                  dready,
    input  logic                  dack,
    input  logic [31:0]           drdata,
    output logic                  err
);
    localparam int PW = $clog2(PORTS);
    localparam int QW = $clog2(QDEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d, grant_q, grant_d, sel, grant_nxt;
    logic [PW:0]     rr_idx;
    logic            sel_vld;
    logic            wr_q, wr_d;
    logic [22:0]     addr_q, addr_d;
    logic [1:0]      len_q, len_d;
    logic [QW:0]     count_q, count_d;
    logic [QW-1:0]   wptr_q, rptr_q;
    logic [1:0]      bcnt_q, bcnt_d;
    logic            err_q, err_d;
    logic [PW-1:0]   qport_q [QDEPTH];
    logic [1:0]      qlen_q  [QDEPTH];
    logic            push, pop, head_vld;
    logic [PW-1:0]   head_port;

    // First requester at or after rr, wrapping past the last port.
    always_comb begin
        sel     = rr_q;
        sel_vld = 1'b0;
        rr_idx  = '0;
        for (int i = 0; i < PORTS; i++) begin
            rr_idx = {1'b0, rr_q} + (PW+1)'(i);
            if (rr_idx >= (PW+1)'(PORTS)) rr_idx = rr_idx - (PW+1)'(PORTS);
            if (!sel_vld && memreq[rr_idx[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel     = rr_idx[PW-1:0];
            end
        end
`ifdef MEMARB_PRIO_EN
        if (memreq[0]) begin
            sel_vld = 1'b1;
            sel     = '0;
        end
`endif
    end

    assign grant_nxt = (grant_q == PW'(PORTS-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        rr_d     = rr_q;
        push     = 1'b0;
        memready = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld && count_q < (QW+1)'(QDEPTH)) begin
                    state_d = REQ;
                    grant_d = sel;
                    wr_d    = memwr[sel];
                    addr_d  = memaddr[int'(sel)*23 +: 23];
                    len_d   = memlen[int'(sel)*2 +: 2];
                end
            end
            REQ: begin
                if (dready) begin
                    memready[grant_q] = 1'b1;
                    push    = 1'b1;
                    state_d = IDLE;
`ifdef MEMARB_PRIO_EN
                    if (grant_q != '0) rr_d = grant_nxt;
`else
                    rr_d = grant_nxt;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_vld  = (count_q != '0);
    assign head_port = qport_q[rptr_q];

    always_comb begin
        memack = '0;
        pop    = 1'b0;
        bcnt_d = bcnt_q;
        err_d  = err_q;
        if (dack) begin
            if (head_vld) begin
                memack[head_port] = 1'b1;
                if (bcnt_q == qlen_q[rptr_q]) begin
                    pop    = 1'b1;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_q + 2'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        dwdata = memwdata[31:0];
        for (int i = 0; i < PORTS; i++)
            if (head_port == PW'(i)) dwdata = memwdata[32*i +: 32];
    end

    assign count_d  = count_q + (QW+1)'(push) - (QW+1)'(pop);
    assign memrdata = drdata;
    assign dreq     = (state_q == REQ);
    assign dwr      = wr_q;
    assign daddr    = addr_q;
    assign dlen     = len_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                qport_q[i] <= '0;
                qlen_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
            if (push) begin
                qport_q[wptr_q] <= grant_q;
                qlen_q[wptr_q]  <= len_q;
                wptr_q          <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_memarb.sv
// Self-checking bench for memarb: directed scenarios plus random traffic checked
// against a transaction-level model (burst owner queue, round-robin pick by rule).
module tb_memarb;
    localparam int PORTS  = 4;
    localparam int QDEPTH = 4;
`ifdef MEMARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                  clk, rstn;
    logic [PORTS-1:0]      memreq, memwr, memready, memack;
    logic [23*PORTS-1:0]   memaddr;
    logic [2*PORTS-1:0]    memlen;
    logic [32*PORTS-1:0]   memwdata;
    logic [31:0]           memrdata, dwdata, drdata;
    logic                  dreq, dwr, dready, dack, err;
    logic [22:0]           daddr;
    logic [1:0]            dlen;

    memarb #(.PORTS(PORTS), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memlen(memlen),
        .memwdata(memwdata), .memready(memready), .memack(memack), .memrdata(memrdata),
        .dreq(dreq), .dwr(dwr), .daddr(daddr), .dlen(dlen), .dwdata(dwdata),
        .dready(dready), .dack(dack), .drdata(drdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    bit          c_req [PORTS];
    bit          c_gap [PORTS];
    bit          c_wr  [PORTS];
    bit          refill[PORTS];
    logic [22:0] c_addr[PORTS];
    logic [1:0]  c_len [PORTS];
    bit          drv_ready, drv_ack, auto_ack, rand_mode;

    typedef struct {int port; int left;} burst_t;
    burst_t m_q[$];
    bit     m_cmd_valid, m_err;
    int     m_grant, m_rr;
    int     obs_grant[$];
    int     obs_ack[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        if (PRIO && c_req[0]) return 0;
        for (int k = 0; k < PORTS; k++)
            if (c_req[(m_rr + k) % PORTS]) return (m_rr + k) % PORTS;
        return -1;
    endfunction

    task automatic set_cmd(input int p, input bit wr, input logic [22:0] a, input logic [1:0] l);
        c_wr[p] = wr; c_addr[p] = a; c_len[p] = l; c_req[p] = 1'b1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < PORTS; i++) begin
            memreq[i]            = c_req[i];
            memwr[i]             = c_wr[i];
            memaddr[23*i +: 23]  = c_addr[i];
            memlen[2*i +: 2]     = c_len[i];
            memwdata[32*i +: 32] = $urandom;
        end
        drdata = $urandom;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step();
        logic [PORTS-1:0] exp_rdy, exp_ack;
        burst_t b;
        int hp, qn0;
        for (int i = 0; i < PORTS; i++) begin
            if (!c_req[i]) begin
                if (c_gap[i]) c_gap[i] = 1'b0;
                else if (refill[i]) set_cmd(i, 1'b0, 23'($urandom), 2'd0);
                else if (rand_mode && $urandom_range(0, 2) == 0)
                    set_cmd(i, 1'($urandom), 23'($urandom), 2'($urandom));
            end
        end
        drive_inputs();
        dready = drv_ready || (rand_mode && $urandom_range(0, 1) == 1);
        dack   = drv_ack || (m_q.size() > 0 && (auto_ack || (rand_mode && $urandom_range(0, 1) == 1)));
        #1;
        chk("dreq", dreq, m_cmd_valid);
        if (m_cmd_valid) begin
            chk("daddr", daddr, c_addr[m_grant]);
            chk("dlen", dlen, c_len[m_grant]);
            chk("dwr", dwr, c_wr[m_grant]);
        end
        exp_rdy = '0;
        if (m_cmd_valid && dready) exp_rdy[m_grant] = 1'b1;
        chk("memready", memready, exp_rdy);
        exp_ack = '0;
        if (dack && m_q.size() > 0) begin
            hp = m_q[0].port;
            exp_ack[hp] = 1'b1;
            chk("dwdata", dwdata, memwdata[32*hp +: 32]);
        end
        chk("memack", memack, exp_ack);
        chk("memrdata", memrdata, drdata);
        chk("err", err, m_err);
        for (int i = 0; i < PORTS; i++) begin
            if (memready[i]) obs_grant.push_back(i);
            if (memack[i])   obs_ack.push_back(i);
        end
        qn0 = m_q.size();
        if (dack) begin
            if (qn0 == 0) m_err = 1'b1;
            else begin
                b = m_q[0];
                b.left--;
                if (b.left == 0) void'(m_q.pop_front());
                else m_q[0] = b;
            end
        end
        if (m_cmd_valid) begin
            if (dready) begin
                b.port = m_grant;
                b.left = int'(c_len[m_grant]) + 1;
                m_q.push_back(b);
                if (!(PRIO && m_grant == 0)) m_rr = (m_grant + 1) % PORTS;
                m_cmd_valid = 1'b0;
                c_req[m_grant] = 1'b0;
                c_gap[m_grant] = 1'b1;
            end
        end else if (qn0 < QDEPTH) begin
            hp = pick();
            if (hp >= 0) begin
                m_grant = hp;
                m_cmd_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            c_req[i] = 0; c_gap[i] = 0; c_wr[i] = 0; refill[i] = 0; c_addr[i] = '0; c_len[i] = '0;
        end
        drv_ready = 0; drv_ack = 0; auto_ack = 0; rand_mode = 0;
        dready = 1'b0; dack = 1'b0;
        drive_inputs();
        m_q.delete(); m_cmd_valid = 0; m_err = 0; m_rr = 0; m_grant = 0;
        obs_grant.delete(); obs_ack.delete();
        @(posedge clk);
        #1;
        chk("rst_dreq", dreq, 0);
        chk("rst_dwr", dwr, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dlen", dlen, 0);
        chk("rst_memready", memready, 0);
        chk("rst_memack", memack, 0);
        chk("rst_err", err, 0);
        rstn = 1'b1;
    endtask

    int exp_seq[6];
    bit seen;

    initial begin
        rstn = 1'b0;
        #2;
        do_reset();

        // single read on port 1
        set_cmd(1, 1'b0, 23'h1337, 2'd3);
        step();
        chk("t1_dreq", dreq, 1);
        chk("t1_daddr", daddr, 23'h1337);
        chk("t1_dlen", dlen, 3);
        drv_ready = 1; step(); drv_ready = 0;
        chk("t1_grants", obs_grant.size(), 1);
        if (obs_grant.size() > 0) chk("t1_grant_port", obs_grant[0], 1);
        drv_ack = 1; repeat (4) step(); drv_ack = 0;
        chk("t1_acks", obs_ack.size(), 4);
        for (int i = 0; i < obs_ack.size(); i++) chk("t1_ack_port", obs_ack[i], 1);
        step();

        // continuous requests, len 0
        do_reset();
        for (int i = 0; i < PORTS; i++) refill[i] = 1;
        drv_ready = 1; auto_ack = 1;
        if (PRIO) exp_seq = '{0, 1, 0, 2, 0, 3};
        else      exp_seq = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 60 && obs_grant.size() < 6; k++) step();
        chk("t2_ngrants", obs_grant.size() >= 6, 1);
        for (int i = 0; i < 6 && i < obs_grant.size(); i++) chk("t2_order", obs_grant[i], exp_seq[i]);

        // interleaved write (port 0) and read (port 2)
        do_reset();
        set_cmd(0, 1'b1, 23'h00100, 2'd1);
        set_cmd(2, 1'b0, 23'h00200, 2'd0);
        drv_ready = 1;
        for (int k = 0; k < 10 && obs_grant.size() < 2; k++) step();
        drv_ready = 0;
        chk("t3_ngrants", obs_grant.size(), 2);
        drv_ack = 1; repeat (3) step(); drv_ack = 0;
        chk("t3_nacks", obs_ack.size(), 3);
        if (obs_ack.size() == 3) begin
            chk("t3_ack0", obs_ack[0], 0);
            chk("t3_ack1", obs_ack[1], 0);
            chk("t3_ack2", obs_ack[2], 2);
        end

        // queue full
        do_reset();
        for (int i = 0; i < PORTS; i++) refill[i] = 1;
        drv_ready = 1;
        repeat (20) step();
        chk("t4_accepted", obs_grant.size(), QDEPTH);
        chk("t4_stalled", dreq, 0);
        drv_ack = 1; step(); drv_ack = 0;
        seen = 0;
        for (int k = 0; k < 2 && !seen; k++) begin
            if (dreq) seen = 1;
            else step();
        end
        chk("t4_resume", seen, 1);

        // dack with empty queue
        do_reset();
        drv_ack = 1; step(); drv_ack = 0;
        chk("t5_noack", obs_ack.size(), 0);
        chk("t5_err", err, 1);
        repeat (3) step();
        chk("t5_err_sticky", err, 1);
        rstn = 1'b0;
        #1;
        chk("t5_err_clr", err, 0);

        // reset while in REQ with two bursts queued
        do_reset();
        set_cmd(0, 1'b0, 23'h00010, 2'd0);
        set_cmd(1, 1'b0, 23'h00020, 2'd0);
        set_cmd(2, 1'b0, 23'h00030, 2'd0);
        drv_ready = 1;
        for (int k = 0; k < 10 && obs_grant.size() < 2; k++) step();
        drv_ready = 0;
        step();
        chk("t6_inreq", dreq, 1);
        rstn = 1'b0;
        #1;
        chk("t6_dreq_drop", dreq, 0);
        do_reset();
        drv_ack = 1; step(); drv_ack = 0;
        chk("t6_flushed_noack", obs_ack.size(), 0);
        chk("t6_err", err, 1);

        // random traffic
        do_reset();
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        auto_ack = 1;
        repeat (40) step();
        chk("rand_activity", obs_grant.size() > 10, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
